pfd_loop_filter: RTL and testbench

Digital loop filter sitting directly downstream of the phase-frequency detector in the ring-oscillator PLL. It consumes the PFD's asynchronous `up`/`down` pulses, synchronises them into the system clock domain, and integrates their widths into an unsigned control word that drives the ring-oscillator tap/trim selection. It also runs a windowed lock detector with hysteresis.

---
 rtl/pfd_loop_filter.sv | 142 ++++++++++++++
 tb/tb_pfd_loop_filter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pfd_loop_filter.sv
// PFD-driven digital loop filter: synchronised up/down pulses feed a saturating
// integrator with optional proportional path (PFD_LF_PROP_PATH_EN) and a windowed lock detector.
module pfd_loop_filter #(
  parameter int CTRL_W     = 8,
  parameter int INT_FRAC   = 4,
  parameter int KP         = 2,
  parameter int WIN_LEN    = 64,
  parameter int LOCK_THR   = 2,
  parameter int UNLOCK_THR = 8,
  parameter int LOCK_N     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up,
  input  logic              down,
  input  logic              hold,
  output logic [CTRL_W-1:0] ctrl_word,
  output logic              locked,
  output logic              sat
);

  localparam int INT_W = CTRL_W + INT_FRAC;
  localparam int WC_W  = $clog2(WIN_LEN);
  localparam int AC_W  = $clog2(WIN_LEN + 1);
  localparam int GC_W  = $clog2(LOCK_N + 1);

  localparam logic [INT_W-1:0]         INT_MAX    = {INT_W{1'b1}};
  localparam logic [INT_W-1:0]         INT_MID    = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [CTRL_W-1:0]        CTRL_MID   = {1'b1, {(CTRL_W-1){1'b0}}};
  localparam logic signed [CTRL_W+1:0] CTRL_MAX_S = (CTRL_W+2)'((1 << CTRL_W) - 1);
  localparam logic [WC_W-1:0]          WIN_LAST   = WC_W'(WIN_LEN - 1);
  localparam logic [AC_W-1:0]          LOCK_THR_C = AC_W'(LOCK_THR);
  localparam logic [AC_W-1:0]          UNLK_THR_C = AC_W'(UNLOCK_THR);
  localparam logic [GC_W-1:0]          GOOD_LAST  = GC_W'(LOCK_N - 1);

  typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

  logic up_meta_q, up_s_q, down_meta_q, down_s_q;
  logic err_pos, err_neg, err_act;
  logic [INT_W-1:0]  integ_q, integ_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              sat_q, sat_d;
  logic signed [CTRL_W+1:0] sum;
  state_t            state_q, state_d;
  logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
  logic [AC_W-1:0]   act_cnt_q, act_cnt_d, act_total;
  logic [GC_W-1:0]   good_cnt_q, good_cnt_d;
  logic              win_end;

  assign err_pos = up_s_q & ~down_s_q;
  assign err_neg = down_s_q & ~up_s_q;
  assign err_act = err_pos | err_neg;

  always_comb begin
    integ_d = integ_q;
    if (!hold) begin
      if (err_pos && integ_q != INT_MAX)
        integ_d = integ_q + INT_W'(1);
      else if (err_neg && integ_q != '0)
        integ_d = integ_q - INT_W'(1);
    end
    sat_d = (integ_d == '0) || (integ_d == INT_MAX);

    sum = signed'({2'b00, integ_d[INT_W-1:INT_FRAC]});
`ifdef PFD_LF_PROP_PATH_EN
    // Proportional kick is applied from the current error even while the integrator is held.
    if (err_pos)
      sum = sum + (CTRL_W+2)'(KP);
    else if (err_neg)
      sum = sum - (CTRL_W+2)'(KP);
`endif
    if (sum < 0)
      ctrl_d = '0;
    else if (sum > CTRL_MAX_S)
      ctrl_d = '1;
    else
      ctrl_d = sum[CTRL_W-1:0];
  end

  always_comb begin
    win_end    = (win_cnt_q == WIN_LAST);
    act_total  = act_cnt_q + AC_W'(err_act);
    win_cnt_d  = win_end ? '0 : win_cnt_q + WC_W'(1);
    act_cnt_d  = win_end ? '0 : act_total;
    good_cnt_d = good_cnt_q;
    state_d    = state_q;
    if (win_end) begin
      case (state_q)
        ACQ: begin
          if (act_total <= LOCK_THR_C) begin
            if (good_cnt_q == GOOD_LAST) begin
              state_d    = TRACK;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + GC_W'(1);
            end
          end else begin
            good_cnt_d = '0;
          end
        end
        TRACK: begin
          if (act_total > UNLK_THR_C)
            state_d = ACQ;
        end
        default: state_d = ACQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_meta_q   <= 1'b0;
      up_s_q      <= 1'b0;
      down_meta_q <= 1'b0;
      down_s_q    <= 1'b0;
      integ_q     <= INT_MID;
      ctrl_q      <= CTRL_MID;
      sat_q       <= 1'b0;
      state_q     <= ACQ;
      win_cnt_q   <= '0;
      act_cnt_q   <= '0;
      good_cnt_q  <= '0;
    end else begin
      up_meta_q   <= up;
      up_s_q      <= up_meta_q;
      down_meta_q <= down;
      down_s_q    <= down_meta_q;
      integ_q     <= integ_d;
      ctrl_q      <= ctrl_d;
      sat_q       <= sat_d;
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      act_cnt_q   <= act_cnt_d;
      good_cnt_q  <= good_cnt_d;
    end
  end

  assign ctrl_word = ctrl_q;
  assign sat       = sat_q;
  assign locked    = (state_q == TRACK);

endmodule

// File: tb/tb_pfd_loop_filter.sv
// Randomised and directed bench for pfd_loop_filter against a cycle-level arithmetic model.
module tb_pfd_loop_filter;
  localparam int CTRL_W = 8, INT_FRAC = 4, KP = 2, WIN_LEN = 64;
  localparam int LOCK_THR = 2, UNLOCK_THR = 8, LOCK_N = 4;
  localparam int INT_MAX  = (1 << (CTRL_W + INT_FRAC)) - 1;
  localparam int CTRL_MAX = (1 << CTRL_W) - 1;
`ifdef PFD_LF_PROP_PATH_EN
  localparam int KP_EFF = KP;
`else
  localparam int KP_EFF = 0;
`endif

  logic clk = 1'b0;
  logic reset, up, down, hold;
  logic [CTRL_W-1:0] ctrl_word;
  logic locked, sat;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: inputs reach the arithmetic two edges after being applied.
  int m_integ, m_ctrl, m_n, m_act, m_good;
  bit m_locked, m_sat;
  bit m_u1, m_d1, m_u2, m_d2;

  pfd_loop_filter #(
    .CTRL_W(CTRL_W), .INT_FRAC(INT_FRAC), .KP(KP), .WIN_LEN(WIN_LEN),
    .LOCK_THR(LOCK_THR), .UNLOCK_THR(UNLOCK_THR), .LOCK_N(LOCK_N)
  ) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .hold(hold),
    .ctrl_word(ctrl_word), .locked(locked), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_integ = 1 << (CTRL_W + INT_FRAC - 1);
    m_ctrl = 1 << (CTRL_W - 1);
    m_n = 0; m_act = 0; m_good = 0;
    m_locked = 0; m_sat = 0;
    m_u1 = 0; m_d1 = 0; m_u2 = 0; m_d2 = 0;
  endtask

  task automatic model_edge(input bit u, input bit d, input bit h);
    int e;
    e = (m_u2 && !m_d2) ? 1 : ((m_d2 && !m_u2) ? -1 : 0);
    if (!h) m_integ = clampi(m_integ + e, 0, INT_MAX);
    m_ctrl = clampi(m_integ / (1 << INT_FRAC) + e * KP_EFF, 0, CTRL_MAX);
    m_sat = (m_integ == 0) || (m_integ == INT_MAX);
    m_n++;
    if (e != 0) m_act++;
    if (m_n % WIN_LEN == 0) begin
      if (!m_locked) begin
        m_good = (m_act <= LOCK_THR) ? m_good + 1 : 0;
        if (m_good == LOCK_N) begin
          m_locked = 1;
          m_good = 0;
        end
      end else if (m_act > UNLOCK_THR) begin
        m_locked = 0;
      end
      m_act = 0;
    end
    m_u2 = m_u1; m_d2 = m_d1;
    m_u1 = u;    m_d1 = d;
  endtask

  task automatic step(input bit u, input bit d, input bit h);
    up = u; down = d; hold = h;
    @(posedge clk);
    model_edge(u, d, h);
    @(negedge clk);
    check("ctrl_word", ctrl_word, m_ctrl);
    check("locked", locked, m_locked);
    check("sat", sat, m_sat);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_ctrl", ctrl_word, 128);
    check("rst_locked", locked, 0);
    check("rst_sat", sat, 0);
    model_reset();
    #1 reset = 1'b0;
  endtask

  task automatic align_window();
    while (m_n % WIN_LEN != 0) step(0, 0, 0);
  endtask

  task automatic active_window(input int k);
    for (int p = 0; p < WIN_LEN; p++) begin
      if (p >= 10 && p < 10 + k) step(p % 2 == 0, p % 2 == 1, 0);
      else step(0, 0, 0);
    end
  endtask

  initial begin
    reset = 1'b1; up = 0; down = 0; hold = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("init_ctrl", ctrl_word, 128);
    check("init_locked", locked, 0);
    check("init_sat", sat, 0);
    reset = 1'b0;

    // up for 16 sampled cycles, then release
    repeat (16) step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("up16_active", ctrl_word, 129 + KP_EFF);
    step(0, 0, 0);
    check("up16_after", ctrl_word, 129);
    check("up16_sat", sat, 0);

    // long up run into saturation, then a single down cycle
    repeat (5000) step(1, 0, 0);
    check("sat_ctrl", ctrl_word, 255);
    check("sat_flag", sat, 1);
    step(0, 1, 0);
    step(0, 0, 0);
    check("sat_hold1", sat, 1);
    step(0, 0, 0);
    check("sat_drop", sat, 0);

    // both-high overlap carries no error; lock at exactly edge 256
    async_reset();
    for (int i = 1; i <= 256; i++) begin
      if (i <= 20) step(1, 1, 0);
      else step(0, 0, 0);
      if (i == 20) check("both_ctrl", ctrl_word, 128);
      if (i == 255) check("lock_255", locked, 0);
      if (i == 256) check("lock_256", locked, 1);
    end

    align_window();
    active_window(8);
    check("win8_keep", locked, 1);
    active_window(10);
    check("win10_drop", locked, 0);
    repeat (LOCK_N) active_window(2);
    check("relock", locked, 1);

    // hold freezes the integrator; only the proportional kick shows
    async_reset();
    repeat (32) step(1, 0, 1);
    check("hold_ctrl", ctrl_word, 128 + KP_EFF);

    // randomised segments
    begin
      int done = 0;
      while (done < 2000) begin
        int mode = $urandom_range(0, 4);
        int len  = $urandom_range(1, 60);
        for (int j = 0; j < len; j++) begin
          bit u, d, h;
          h = ($urandom_range(0, 9) == 0);
          case (mode)
            0: begin u = 0; d = 0; end
            1: begin u = 1; d = 0; end
            2: begin u = 0; d = 1; end
            3: begin u = 1; d = 1; end
            default: begin u = $urandom_range(0, 1); d = $urandom_range(0, 1); end
          endcase
          step(u, d, h);
        end
        done += len;
      end
    end

    // reset mid-window with integ off midscale; next lock needs a full 256 cycles
    repeat (40) step(1, 0, 0);
    async_reset();
    for (int i = 1; i <= 256; i++) begin
      step(0, 0, 0);
      if (i == 255) check("relock_255", locked, 0);
      if (i == 256) check("relock_256", locked, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
